spike_event_scheduler: RTL

SPIKE_EVENT_SCHEDULER -- requirements
Module: spike_event_scheduler

---
 rtl/spike_event_scheduler_if.sv | 40 ++++
 rtl/spike_event_scheduler.sv | 106 ++++++++++
 2 files changed

// File: rtl/spike_event_scheduler_if.sv
// Requester, synapse-array and response signals of the spike event scheduler.
// master = requesters/array/consumer side, slave = scheduler.
interface spike_event_scheduler_if #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 4,
    parameter int WEIGHT_WIDTH = 8
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_learn;
    logic [NUM_REQ*8-1:0]          req_delta;
    logic                          learn_enable;

    logic                          syn_spike;
    logic [ADDR_WIDTH-1:0]         syn_addr;
    logic                          syn_learn;
    logic [7:0]                    syn_delta;
    logic [WEIGHT_WIDTH-1:0]       syn_weight;

    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_W-1:0]               rsp_id;
    logic [WEIGHT_WIDTH-1:0]       rsp_weight;
    logic [15:0]                   event_count;

    modport master (
        output req_valid, req_addr, req_learn, req_delta, learn_enable, syn_weight, rsp_ready,
        input  req_ready, syn_spike, syn_addr, syn_learn, syn_delta,
               rsp_valid, rsp_id, rsp_weight, event_count
    );

    modport slave (
        input  req_valid, req_addr, req_learn, req_delta, learn_enable, syn_weight, rsp_ready,
        output req_ready, syn_spike, syn_addr, syn_learn, syn_delta,
               rsp_valid, rsp_id, rsp_weight, event_count
    );
endinterface

// File: rtl/spike_event_scheduler.sv
// Round-robin scheduler serialising spike events from NUM_REQ requesters onto one
// synapse array: IDLE -> ISSUE -> WAIT -> RESP, one event in flight.
module spike_event_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 4,
    parameter int WEIGHT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    spike_event_scheduler_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic                  spike;
        logic [ADDR_WIDTH-1:0] addr;
        logic                  learn;
        logic [7:0]            delta;
    } syn_cmd_t;

    state_t                  state;
    syn_cmd_t                syn;
    logic [ID_W-1:0]         evt_id;
    logic [ID_W-1:0]         last_grant;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [WEIGHT_WIDTH-1:0] rsp_weight;
    logic [15:0]             evt_cnt;

    logic                    gnt_vld;
    logic [ID_W-1:0]         grant;
    logic [ID_W-1:0]         cand;
    logic [NUM_REQ-1:0]      ready;

    // Walk from the farthest candidate down to last_grant+1 so the nearest valid one wins.
    always_comb begin
        gnt_vld = 1'b0;
        grant   = '0;
        cand    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = ID_W'((int'(last_grant) + i) % NUM_REQ);
            if (bus.req_valid[cand]) begin
                gnt_vld = 1'b1;
                grant   = cand;
            end
        end
    end

    always_comb begin
        ready = '0;
        if (state == IDLE && gnt_vld && !rst) ready[grant] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            syn        <= '0;
            evt_id     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_weight <= '0;
            evt_cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (gnt_vld) begin
                    syn.spike <= 1'b1;
                    syn.addr  <= bus.req_addr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
                    syn.learn <= bus.req_learn[grant] & bus.learn_enable;
                    syn.delta <= bus.req_delta[int'(grant)*8 +: 8];
                    evt_id    <= grant;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    syn   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    rsp_weight <= bus.syn_weight;
                    rsp_id     <= evt_id;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    rsp_valid  <= 1'b0;
                    last_grant <= rsp_id;
                    if (evt_cnt != 16'hFFFF) evt_cnt <= evt_cnt + 16'd1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = ready;
    assign bus.syn_spike   = syn.spike;
    assign bus.syn_addr    = syn.addr;
    assign bus.syn_learn   = syn.learn;
    assign bus.syn_delta   = syn.delta;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_id      = rsp_id;
    assign bus.rsp_weight  = rsp_weight;
    assign bus.event_count = evt_cnt;
endmodule
